// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus slave.
// Contents: register byte offsets, TCON bit indices, default base address, register-select
// enum and the address decode helper used by the top level.
package periph_bus_pkg;

  // Register byte offsets from the peripheral base address
  localparam logic [7:0] TH_OFF      = 8'h00;
  localparam logic [7:0] TL_OFF      = 8'h04;
  localparam logic [7:0] TCON_OFF    = 8'h08;
  localparam logic [7:0] LED_OFF     = 8'h0C;
  localparam logic [7:0] SWITCH_OFF  = 8'h10;
  localparam logic [7:0] SYSTICK_OFF = 8'h14;

  // TCON bit indices
  localparam int unsigned TCON_EN = 0;  // count enable
  localparam int unsigned TCON_IE = 1;  // interrupt enable
  localparam int unsigned TCON_IS = 2;  // interrupt status

  localparam logic [31:0] BASE_DEFAULT = 32'h4000_0000;

  typedef enum logic [2:0] {
    SelNone,
    SelTh,
    SelTl,
    SelTcon,
    SelLed,
    SelSwitch,
    SelSystick
  } reg_sel_e;

  // Word-granular decode: addr[1:0] is ignored, addr[31:2] is compared in full. Any address
  // outside the block yields an offset that matches no case item.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    reg_sel_e    sel;
    off = {addr[31:2], 2'b00} - {base[31:2], 2'b00};
    case (off)
      {24'h0, TH_OFF}:      sel = SelTh;
      {24'h0, TL_OFF}:      sel = SelTl;
      {24'h0, TCON_OFF}:    sel = SelTcon;
      {24'h0, LED_OFF}:     sel = SelLed;
      {24'h0, SWITCH_OFF}:  sel = SelSwitch;
      {24'h0, SYSTICK_OFF}: sel = SelSystick;
      default:              sel = SelNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/periph_bus_timer_core.sv
// Reloading timer with interrupt status.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   i_wr_th/tl/tcon   decoded write strobes for TH, TL, TCON
//   i_wdata           store data
//   o_th, o_tl        reload and count registers
//   o_tcon            {irq status, irq enable, count enable}
// While enabled TL counts up; on TL == all-ones it reloads from TH and, if enabled, sets the
// interrupt status. Bus writes to TL beat the counter; a TCON write cannot clear a status bit
// being set in the same cycle.
module periph_bus_timer_core
  import periph_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_th,
  input  logic        i_wr_tl,
  input  logic        i_wr_tcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_ovf;
  logic        w_irq_set;

  assign w_ovf     = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);
  assign w_irq_set = w_ovf && r_tcon[TCON_IE];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (i_wr_th) begin
        r_th <= i_wdata;
      end
      // Reload uses the pre-edge TH, so a simultaneous TH write only affects the next reload
      if (i_wr_tl) begin
        r_tl <= i_wdata;
      end else if (r_tcon[TCON_EN]) begin
        r_tl <= w_ovf ? r_th : r_tl + 32'd1;
      end
      if (i_wr_tcon) begin
        r_tcon <= {i_wdata[TCON_IS] | w_irq_set, i_wdata[TCON_IE], i_wdata[TCON_EN]};
      end else if (w_irq_set) begin
        r_tcon[TCON_IS] <= 1'b1;
      end
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;

endmodule

// File: rtl/periph_bus.sv
// Memory-mapped peripheral slave sitting after the ALU (ALU result = load/store address).
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   rd, wr       MEM-stage load/store strobes
//   addr, wdata  byte address and store data
//   rdata        combinational read data (0 when rd is low or address unmapped)
//   led          LED register
//   switch       asynchronous switch pins, two-flop synchronised
//   irqout       registered timer interrupt status (TCON[2])
// Map (from BASE): 0x00 TH, 0x04 TL, 0x08 TCON, 0x0C LED, 0x10 SWITCH ro, 0x14 SYSTICK ro.
module periph_bus
  import periph_bus_pkg::*;
#(
  parameter int unsigned LED_W = 8,
  parameter int unsigned SW_W  = 8,
  parameter logic [31:0] BASE  = BASE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch,
  output logic             irqout
);

  reg_sel_e         w_sel;
  logic             w_wr_th;
  logic             w_wr_tl;
  logic             w_wr_tcon;
  logic [31:0]      w_th;
  logic [31:0]      w_tl;
  logic [2:0]       w_tcon;
  logic [31:0]      w_led_ext;
  logic [31:0]      w_sw_ext;
  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_sw_meta;
  logic [SW_W-1:0]  r_sw_sync;
  logic [31:0]      r_systick;

  assign w_sel     = decode_addr(addr, BASE);
  assign w_wr_th   = wr && (w_sel == SelTh);
  assign w_wr_tl   = wr && (w_sel == SelTl);
  assign w_wr_tcon = wr && (w_sel == SelTcon);

  periph_bus_timer_core u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_wr_th   (w_wr_th),
    .i_wr_tl   (w_wr_tl),
    .i_wr_tcon (w_wr_tcon),
    .i_wdata   (wdata),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_systick <= '0;
    end else begin
      if (wr && (w_sel == SelLed)) begin
        r_led <= wdata[LED_W-1:0];
      end
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
      r_systick <= r_systick + 32'd1;
    end
  end

  always_comb begin
    w_led_ext              = '0;
    w_led_ext[LED_W-1:0]   = r_led;
    w_sw_ext               = '0;
    w_sw_ext[SW_W-1:0]     = r_sw_sync;
    rdata                  = '0;
    if (rd) begin
      case (w_sel)
        SelTh:      rdata = w_th;
        SelTl:      rdata = w_tl;
        SelTcon:    rdata = {29'd0, w_tcon};
        SelLed:     rdata = w_led_ext;
        SelSwitch:  rdata = w_sw_ext;
        SelSystick: rdata = r_systick;
        default:    rdata = '0;
      endcase
    end
  end

  assign led    = r_led;
  assign irqout = w_tcon[TCON_IS];

endmodule

// File: tb/tb_periph_bus.sv
module tb_periph_bus;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [7:0]  sw;
  logic        irqout;

  always #5 clk = ~clk;

  periph_bus #(
    .LED_W (8),
    .SW_W  (8),
    .BASE  (B)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .led    (led),
    .switch (sw),
    .irqout (irqout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led, m_s1, m_s2;

  // Last sampled DUT outputs, for literal checks
  logic [31:0] s_rdata;
  logic        s_irq;
  logic [7:0]  s_led;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == B + 32'h00) return m_th;
    if (w == B + 32'h04) return m_tl;
    if (w == B + 32'h08) return {29'd0, m_tcon};
    if (w == B + 32'h0C) return {24'd0, m_led};
    if (w == B + 32'h10) return {24'd0, m_s2};
    if (w == B + 32'h14) return m_systick;
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive, compare at negedge against model, advance model at posedge.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic rst);
    logic [31:0] wa;
    logic        ovf;
    logic        set;
    logic [31:0] n_tl, n_th;
    logic [2:0]  n_tcon;
    reset = rst; rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    s_rdata = rdata; s_irq = irqout; s_led = led;
    check("rdata", rdata, r ? m_read(a) : 32'd0);
    check("led", {24'd0, led}, {24'd0, m_led});
    check("irqout", {31'd0, irqout}, {31'd0, m_tcon[2]});
    @(posedge clk);
    if (rst) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_systick = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      set    = ovf && m_tcon[1];
      n_th   = m_th;
      n_tl   = m_tcon[0] ? (ovf ? m_th : m_tl + 1) : m_tl;
      n_tcon = {m_tcon[2] | set, m_tcon[1:0]};
      wa     = {a[31:2], 2'b00};
      if (w) begin
        if (wa == B + 32'h00) n_th = d;
        if (wa == B + 32'h04) n_tl = d;
        if (wa == B + 32'h08) n_tcon = {d[2] | set, d[1:0]};
        if (wa == B + 32'h0C) m_led = d[7:0];
      end
      m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
      m_systick = m_systick + 1;
      m_s2 = m_s1;
      m_s1 = sw;
    end
    #1;
  endtask

  task automatic wr_reg(input logic [7:0] off, input logic [31:0] d);
    step(1'b0, 1'b1, B + {24'd0, off}, d, 1'b0);
  endtask

  task automatic rd_reg(input logic [7:0] off);
    step(1'b1, 1'b0, B + {24'd0, off}, 32'd0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  logic [31:0] t1, t2, ra, rdv;

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sw = '0;
    repeat (2) @(posedge clk);
    #1;
    m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_systick = 0; m_s1 = 0; m_s2 = 0;

    // Reset state
    rd_reg(8'h14); check("lit_systick_reset", s_rdata, 32'd0);
    rd_reg(8'h04); check("lit_tl_reset", s_rdata, 32'd0);
    check("lit_irq_reset", {31'd0, s_irq}, 32'd0);

    // Timer reload sequence
    wr_reg(8'h00, 32'hFFFF_FFFD);
    wr_reg(8'h04, 32'hFFFF_FFFE);
    wr_reg(8'h08, 32'd3);
    rd_reg(8'h04); check("lit_tl0", s_rdata, 32'hFFFF_FFFE);
    rd_reg(8'h04); check("lit_tl1", s_rdata, 32'hFFFF_FFFF);
    check("lit_irq_prewrap", {31'd0, s_irq}, 32'd0);
    rd_reg(8'h04); check("lit_tl2", s_rdata, 32'hFFFF_FFFD);
    check("lit_irq_wrap", {31'd0, s_irq}, 32'd1);
    rd_reg(8'h04); check("lit_tl3", s_rdata, 32'hFFFF_FFFE);

    // TL is FFFF_FFFF now: clearing on an overflow cycle must not clear
    wr_reg(8'h08, 32'd3);
    idle(); check("lit_irq_hw_set_wins", {31'd0, s_irq}, 32'd1);
    // No overflow this cycle: clear takes effect
    wr_reg(8'h08, 32'd3);
    idle(); check("lit_irq_cleared", {31'd0, s_irq}, 32'd0);

    // Collision: TL write on an overflow cycle wins over reload
    wr_reg(8'h04, 32'hFFFF_FFFF);
    wr_reg(8'h04, 32'h10);
    rd_reg(8'h04); check("lit_tl_write_wins", s_rdata, 32'h10);
    wr_reg(8'h08, 32'd0);
    rd_reg(8'h04); check("lit_tl_hold_a", s_rdata, 32'h12);
    rd_reg(8'h04); check("lit_tl_hold_b", s_rdata, 32'h12);

    // LED, switch, unmapped
    wr_reg(8'h0C, 32'h1A5);
    idle(); check("lit_led", {24'd0, s_led}, 32'hA5);
    sw = 8'h3C;
    rd_reg(8'h10);
    rd_reg(8'h10); check("lit_sw_not_yet", s_rdata, 32'h0);
    rd_reg(8'h10); check("lit_sw", s_rdata, 32'h3C);
    step(1'b1, 1'b0, B + 32'h13, 32'd0, 1'b0); check("lit_sw_byte_addr", s_rdata, 32'h3C);
    step(1'b1, 1'b0, B + 32'h20, 32'd0, 1'b0); check("lit_unmapped", s_rdata, 32'h0);
    step(1'b1, 1'b0, 32'h5000_0000, 32'd0, 1'b0); check("lit_other_base", s_rdata, 32'h0);

    // Systick
    rd_reg(8'h14); t1 = s_rdata;
    repeat (4) idle();
    rd_reg(8'h14); t2 = s_rdata;
    check("lit_systick_delta", t2 - t1, 32'd5);
    wr_reg(8'h14, 32'h1234);
    rd_reg(8'h14); check("lit_systick_ro", s_rdata, t2 + 32'd2);

    // Reset mid-activity
    wr_reg(8'h00, 32'hFFFF_FFF0);
    wr_reg(8'h04, 32'hFFFF_FFFC);
    wr_reg(8'h08, 32'd3);
    repeat (6) idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    rd_reg(8'h14); check("lit_rst_systick", s_rdata, 32'd0);
    check("lit_rst_led", {24'd0, s_led}, 32'd0);
    check("lit_rst_irq", {31'd0, s_irq}, 32'd0);
    rd_reg(8'h04); check("lit_rst_tl", s_rdata, 32'd0);
    rd_reg(8'h00); check("lit_rst_th", s_rdata, 32'd0);
    rd_reg(8'h08); check("lit_rst_tcon", s_rdata, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 9) == 0) ra = $urandom;
      else ra = B + {24'd0, 3'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
      case ($urandom_range(0, 3))
        0:       rdv = 32'hFFFF_FFFF - $urandom_range(0, 4);
        1:       rdv = 32'($urandom_range(0, 7));
        default: rdv = $urandom;
      endcase
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ra, rdv,
           ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
